// File: rtl/noc_reset_sequencer.sv
// rtl/noc_reset_sequencer.sv - ordered NoC domain reset release with warm-reset quiesce
module noc_reset_sequencer #(
  parameter int NUM_DOM = 4,
  parameter int RLS_GAP = 8,
  parameter int ACK_TMO = 255
) (
  input  logic               clock,
  input  logic               reset_local,
  input  logic               rst_sync_n,
  input  logic               safeshift,
  input  logic               warm_req,
  output logic [NUM_DOM-1:0] quiesce_req,
  input  logic [NUM_DOM-1:0] quiesce_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               tmo_err
);

  localparam int GW = $clog2(RLS_GAP);
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam int IW = $clog2(NUM_DOM);

  localparam logic [GW-1:0] GAP_LAST = GW'(RLS_GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_QUIESCE,
    S_ASSERT
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic [NUM_DOM-1:0] quiesce_req_q, quiesce_req_d;
  logic               seq_busy_q, seq_busy_d;
  logic               seq_done_q, seq_done_d;
  logic               tmo_err_q, tmo_err_d;
  logic [NUM_DOM-1:0] rel_bit;

  // Domain index currently being released, as a one-hot mask.
  assign rel_bit = NUM_DOM'(1) << idx_q;

  // Next-state and next-output computation for the release/quiesce sequencer.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    idx_d         = idx_q;
    dom_rst_d     = dom_rst_q;
    quiesce_req_d = quiesce_req_q;
    tmo_err_d     = tmo_err_q;

    case (state_q)
      S_HOLD: begin
        dom_rst_d = '0;
        if (rst_sync_n) begin
          state_d   = S_RELEASE;
          gap_cnt_d = '0;
          idx_d     = '0;
        end
      end

      S_RELEASE: begin
        if (gap_cnt_q == GAP_LAST) begin
          dom_rst_d = dom_rst_q | rel_bit;
          gap_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (warm_req) begin
          state_d       = S_QUIESCE;
          quiesce_req_d = '1;
          tmo_cnt_d     = '0;
        end
      end

      S_QUIESCE: begin
        // Full acknowledge takes priority over a timeout on the same edge.
        if (&quiesce_ack) begin
          state_d   = S_ASSERT;
          dom_rst_d = '0;
          gap_cnt_d = '0;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_ASSERT;
          tmo_err_d = 1'b1;
          dom_rst_d = '0;
          gap_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_ASSERT: begin
        dom_rst_d = '0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d       = S_RELEASE;
          quiesce_req_d = '0;
          gap_cnt_d     = '0;
          idx_d         = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_HOLD;
        dom_rst_d = '0;
        gap_cnt_d = '0;
        tmo_cnt_d = '0;
        idx_d     = '0;
      end
    endcase

    // Loss of the synchronized reset overrides everything except the sticky error.
    if (!rst_sync_n) begin
      state_d       = S_HOLD;
      dom_rst_d     = '0;
      quiesce_req_d = '0;
      gap_cnt_d     = '0;
      tmo_cnt_d     = '0;
      idx_d         = '0;
    end

    seq_busy_d = (state_d == S_RELEASE) || (state_d == S_QUIESCE) || (state_d == S_ASSERT);
    seq_done_d = (state_d == S_RUN);
  end

  // State, counter and registered-output flops with asynchronous block reset.
  always_ff @(posedge clock or negedge reset_local) begin
    if (!reset_local) begin
      state_q       <= S_HOLD;
      gap_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      idx_q         <= '0;
      dom_rst_q     <= '0;
      quiesce_req_q <= '0;
      seq_busy_q    <= 1'b0;
      seq_done_q    <= 1'b0;
      tmo_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      idx_q         <= idx_d;
      dom_rst_q     <= dom_rst_d;
      quiesce_req_q <= quiesce_req_d;
      seq_busy_q    <= seq_busy_d;
      seq_done_q    <= seq_done_d;
      tmo_err_q     <= tmo_err_d;
    end
  end

  // Safe-shift forces domains out of reset without touching sequencer state.
  assign dom_rst_n   = dom_rst_q | {NUM_DOM{safeshift}};
  assign quiesce_req = quiesce_req_q;
  assign seq_busy    = seq_busy_q;
  assign seq_done    = seq_done_q;
  assign tmo_err     = tmo_err_q;

endmodule

// File: tb/tb_noc_reset_sequencer.sv
// tb/tb_noc_reset_sequencer.sv - directed table-driven bench for noc_reset_sequencer
module tb_noc_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_local;
  logic       rst_sync_n;
  logic       safeshift;
  logic       warm_req;
  logic [3:0] quiesce_req;
  logic [3:0] quiesce_ack;
  logic [3:0] dom_rst_n;
  logic       seq_busy;
  logic       seq_done;
  logic       tmo_err;

  int total = 0;
  int bad   = 0;

  noc_reset_sequencer #(.NUM_DOM(4), .RLS_GAP(8), .ACK_TMO(255)) dut (
    .clock       (clock),
    .reset_local (reset_local),
    .rst_sync_n  (rst_sync_n),
    .safeshift   (safeshift),
    .warm_req    (warm_req),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .dom_rst_n   (dom_rst_n),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .tmo_err     (tmo_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    int         cyc;
    logic       rsn;
    logic       ss;
    logic       warm;
    logic [3:0] ack;
    logic [3:0] e_dom;
    logic [3:0] e_qreq;
    logic       e_busy;
    logic       e_done;
    logic       e_tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input int cyc, input logic rsn, input logic ss,
                     input logic warm, input logic [3:0] ack, input logic [3:0] e_dom,
                     input logic [3:0] e_qreq, input logic e_busy, input logic e_done,
                     input logic e_tmo);
    vec_t v;
    v.name = name; v.cyc = cyc; v.rsn = rsn; v.ss = ss; v.warm = warm; v.ack = ack;
    v.e_dom = e_dom; v.e_qreq = e_qreq; v.e_busy = e_busy; v.e_done = e_done; v.e_tmo = e_tmo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] e_dom, input logic [3:0] e_qreq,
                       input logic e_busy, input logic e_done, input logic e_tmo);
    total++;
    if (dom_rst_n !== e_dom || quiesce_req !== e_qreq || seq_busy !== e_busy ||
        seq_done !== e_done || tmo_err !== e_tmo) begin
      bad++;
      $display("FAIL %s: got dom=%b qreq=%b busy=%b done=%b tmo=%b want dom=%b qreq=%b busy=%b done=%b tmo=%b",
               name, dom_rst_n, quiesce_req, seq_busy, seq_done, tmo_err,
               e_dom, e_qreq, e_busy, e_done, e_tmo);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
    #1;
  endtask

  initial begin
    //   name            cyc rsn ss wrm ack      dom      qreq     bsy dn tmo
    add("reset_state",     0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add("ss_hold_on",      0, 0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add("ss_hold_off",     0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add("ss_hold_clk",     2, 0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add("cold_e0",         1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
    add("cold_e7",         7, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
    add("cold_e8",         1, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    add("cold_e15",        7, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    add("cold_e16",        1, 1, 0, 0, 4'b0000, 4'b0011, 4'b0000, 1, 0, 0);
    add("cold_e24",        8, 1, 0, 0, 4'b0000, 4'b0111, 4'b0000, 1, 0, 0);
    add("cold_e31",        7, 1, 0, 0, 4'b0000, 4'b0111, 4'b0000, 1, 0, 0);
    add("cold_e32",        1, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0);
    add("run_stable",      5, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0);
    add("warm_enter",      1, 1, 0, 1, 4'b0000, 4'b1111, 4'b1111, 1, 0, 0);
    add("warm_wait5",      5, 1, 0, 0, 4'b0000, 4'b1111, 4'b1111, 1, 0, 0);
    add("warm_acked",      1, 1, 0, 0, 4'b1111, 4'b0000, 4'b1111, 1, 0, 0);
    add("warm_assert7",    7, 1, 0, 0, 4'b0000, 4'b0000, 4'b1111, 1, 0, 0);
    add("warm_assert8",    1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
    add("warm_rel0",       8, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    add("warm_run",       24, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0);
    add("tie_enter",       1, 1, 0, 1, 4'b0111, 4'b1111, 4'b1111, 1, 0, 0);
    add("tie_wait254",   254, 1, 0, 1, 4'b0111, 4'b1111, 4'b1111, 1, 0, 0);
    add("tie_ack_wins",    1, 1, 0, 1, 4'b1111, 4'b0000, 4'b1111, 1, 0, 0);
    add("tie_assert_end",  8, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
    add("warm_ign_rel",   31, 1, 0, 1, 4'b0000, 4'b0111, 4'b0000, 1, 0, 0);
    add("tie_run",         1, 1, 0, 1, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0);
    add("held_warm_req",   1, 1, 0, 1, 4'b0000, 4'b1111, 4'b1111, 1, 0, 0);
    add("tmo_wait254",   254, 1, 0, 0, 4'b0111, 4'b1111, 4'b1111, 1, 0, 0);
    add("tmo_fire",        1, 1, 0, 0, 4'b0111, 4'b0000, 4'b1111, 1, 0, 1);
    add("tmo_assert_end",  8, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1);
    add("tmo_rel1",       16, 1, 0, 0, 4'b0000, 4'b0011, 4'b0000, 1, 0, 1);
    add("drop_edge",       1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1);
    add("drop_hold",       3, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1);
    add("restart_e0",      1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1);
    add("restart_e7",      7, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1);
    add("restart_e8",      1, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 1);
    add("restart_e31",    23, 1, 0, 0, 4'b0000, 4'b0111, 4'b0000, 1, 0, 1);
    add("restart_run",     1, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 1);

    reset_local = 1'b0;
    rst_sync_n  = 1'b0;
    safeshift   = 1'b0;
    warm_req    = 1'b0;
    quiesce_ack = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    reset_local = 1'b1;
    #1;

    foreach (vecs[i]) begin
      rst_sync_n  = vecs[i].rsn;
      safeshift   = vecs[i].ss;
      warm_req    = vecs[i].warm;
      quiesce_ack = vecs[i].ack;
      if (vecs[i].cyc == 0) #1;
      else run_cycles(vecs[i].cyc);
      check(vecs[i].name, vecs[i].e_dom, vecs[i].e_qreq, vecs[i].e_busy,
            vecs[i].e_done, vecs[i].e_tmo);
    end

    // Sync reset drop while quiescing clears requests, keeps the sticky error.
    warm_req = 1'b1;
    run_cycles(1);
    check("q2_enter", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    warm_req   = 1'b0;
    rst_sync_n = 1'b0;
    run_cycles(1);
    check("q_drop", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    rst_sync_n = 1'b1;
    run_cycles(33);
    check("q_drop_rerun", 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1);

    // Asynchronous block reset during QUIESCE takes effect with no clock edge.
    warm_req = 1'b1;
    run_cycles(1);
    check("q3_enter", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    warm_req = 1'b0;
    #2;
    reset_local = 1'b0;
    #1;
    check("async_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_reset_sequencer.md
Name: noc_reset_sequencer

Overview:
- Consumes the synchronized router reset (rst_sync_n, already in the clock domain) and releases NUM_DOM downstream NoC reset domains one at a time, in index order, with a fixed gap between releases.
- Handles warm-reset requests in RUN: quiesces all domains (req/ack handshake, with timeout), asserts all domain resets, then re-runs the ordered release.
- Sits directly downstream of the router reset synchronizer; drives per-port and per-router-slice resets.

Parameters:
- NUM_DOM, 4: number of reset domains (2..8).
- RLS_GAP, 8: cycles between successive domain releases; also the reset hold time in ASSERT (>=2).
- ACK_TMO, 255: maximum cycles to wait for quiesce acks (<=1023).

Ports:
- clock, in, 1: NoC clock.
- reset_local, in, 1: asynchronous, active-low block reset.
- rst_sync_n, in, 1: synchronized active-low reset from the reset synchronizer.
- safeshift, in, 1: scan/safe-shift override; forces all dom_rst_n high.
- warm_req, in, 1: warm-reset request (level); sampled only in RUN.
- quiesce_req, out, NUM_DOM: per-domain request to drain traffic.
- quiesce_ack, in, NUM_DOM: per-domain "drained" acknowledge.
- dom_rst_n, out, NUM_DOM: active-low domain resets.
- seq_busy, out, 1: high in RELEASE, QUIESCE and ASSERT.
- seq_done, out, 1: high in RUN only (all domains released).
- tmo_err, out, 1: sticky quiesce-timeout flag.

Behaviour:
- Reset (reset_local=0, asynchronous):
  - state=HOLD, all counters 0.
  - dom_rst_q=0, quiesce_req=0, seq_busy=0, seq_done=0, tmo_err=0.
- Output logic:
  - dom_rst_n = dom_rst_q | {NUM_DOM{safeshift}}. Combinational OR, no state change from safeshift.
  - All other outputs are registered.
- HOLD:
  - dom_rst_q=0.
  - rst_sync_n sampled 1 at edge N -> RELEASE after edge N, with gap_cnt=0 and idx=0.
- RELEASE:
  - gap_cnt increments every cycle.
  - On the edge where gap_cnt==RLS_GAP-1: set dom_rst_q[idx]=1, idx++, gap_cnt=0.
  - Result: domain i rises after edge N+(i+1)*RLS_GAP.
  - The edge that releases idx==NUM_DOM-1 also moves to RUN.
- RUN:
  - seq_done=1.
  - warm_req=1 -> QUIESCE: quiesce_req={NUM_DOM{1}}, tmo_cnt=0.
- QUIESCE:
  - tmo_cnt increments every cycle.
  - &quiesce_ack==1 -> ASSERT.
  - Otherwise, when tmo_cnt==ACK_TMO-1: set tmo_err=1, then go to ASSERT.
  - If all acks arrive on the same edge as the timeout, acks win: tmo_err is not set.
- ASSERT:
  - dom_rst_q=0 on entry; hold for RLS_GAP cycles.
  - On exit: quiesce_req=0 and go to RELEASE (gap_cnt=0, idx=0).
- warm_req is ignored outside RUN. A request still high when RUN is re-entered starts a new cycle.
- rst_sync_n sampled 0 in any state:
  - Next state is HOLD.
  - dom_rst_q=0 and quiesce_req=0 after the same edge.
  - tmo_err is preserved.
- Counter widths: gap_cnt is clog2(RLS_GAP), tmo_cnt is clog2(ACK_TMO+1), idx is clog2(NUM_DOM). No counter wraps; each is cleared on every state entry.
- Release order is always index 0 first. Domain resets are never released out of order, and never partially re-asserted.

Test Plan:
- Cold release (NUM_DOM=4, RLS_GAP=8): rst_sync_n sampled high at edge 0 -> dom_rst_n=0001 @8, 0011 @16, 0111 @24, 1111 @32; seq_done=1 and seq_busy=0 from edge 32.
- Warm reset: in RUN, warm_req pulse; quiesce_ack=1111 five cycles after quiesce_req -> dom_rst_n=0000 for 8 cycles, quiesce_req falls, then re-release 8 cycles apart; tmo_err=0.
- Timeout: quiesce_ack stuck at 0111 -> ASSERT entered after 255 QUIESCE cycles; tmo_err=1, and it stays 1 through the next release and RUN.
- Mid-sequence drop: rst_sync_n falls after dom_rst_n=0011 -> 0000 after next edge, state HOLD; rst_sync_n high again -> full restart from domain 0 at +8.
- safeshift: in HOLD, safeshift=1 -> dom_rst_n=1111 in the same cycle; safeshift=0 -> back to 0000; the sequence timing in scenario 1 is unchanged.
- Async reset: reset_local=0 during QUIESCE -> immediately quiesce_req=0, dom_rst_n=0000, tmo_err=0, seq_done=0, with no clock edge required.
